// File: rtl/fila_resposta.sv
// Response queue between the sensor front end and the UART transmitter.
// Buffers (command, value) pairs and releases them one frame at a time with an inter-frame gap.
module fila_resposta #(
    parameter int DEPTH          = 4,
    parameter int ADDR_W         = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_command,
    input  logic [7:0]        in_value,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              out_start,
    output logic [7:0]        out_command,
    output logic [7:0]        out_value,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              tx_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               push;
    logic               pop;
    logic               to_expired;

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    // Room is judged on the pre-edge count, so a same-cycle pop never frees a slot for the push.
    assign push       = in_valid && !full;
    assign pop        = (state == IDLE) && !empty && !tx_busy;
    assign to_expired = (to_cnt == TO_LAST);
    assign out_start  = (state == START);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pop) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (tx_done || to_expired) state_next = GAP;
            GAP:       if (gap_cnt == '0) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_command, in_value};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_command <= '0;
            out_value   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (in_valid) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr                   <= rd_ptr + 1'b1;
                {out_command, out_value} <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // An abandoned frame still gets the full gap so the UART can settle before the next start.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt    <= '0;
            to_cnt     <= '0;
            tx_timeout <= 1'b0;
        end else begin
            case (state)
                START: to_cnt <= '0;
                WAIT_DONE: begin
                    if (tx_done) begin
                        gap_cnt <= GAP_LOAD;
                    end else if (to_expired) begin
                        gap_cnt    <= GAP_LOAD;
                        tx_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fila_resposta.sv
// Self-checking bench for fila_resposta: a directed vector table plus hand-written
// sequences for latency, ordering/wrap, overflow, simultaneous push/pop, timeout and reset.
module tb_fila_resposta;

    localparam int GAP = 4;
    localparam int TMO = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_command;
    logic [7:0] in_value;
    logic       tx_busy;
    logic       tx_done;
    logic       out_start;
    logic [7:0] out_command;
    logic [7:0] out_value;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       tx_timeout;

    logic       man_busy, man_done;
    logic       auto_en = 1'b0;
    logic       auto_busy = 1'b0, auto_done = 1'b0;
    int         auto_lat = 10;
    int         checks = 0;
    int         errors = 0;
    int         start_pulses = 0;
    int         max_count = 0;
    logic [15:0] got[$];

    assign tx_busy = auto_en ? auto_busy : man_busy;
    assign tx_done = auto_en ? auto_done : man_done;

    fila_resposta #(
        .DEPTH(4), .ADDR_W(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_command(in_command), .in_value(in_value),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .out_start(out_start), .out_command(out_command), .out_value(out_value),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .tx_timeout(tx_timeout)
    );

    always #5 clock = ~clock;

    // Frame monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (out_start) begin
            start_pulses++;
            got.push_back({out_command, out_value});
        end
        if (int'(count) > max_count) max_count = int'(count);
    end

    // Simple UART stand-in: busy for auto_lat cycles after each start, then a done strobe.
    initial begin
        forever begin
            @(negedge clock);
            if (auto_en && out_start) begin
                auto_busy = 1'b1;
                repeat (auto_lat - 1) @(negedge clock);
                auto_done = 1'b1;
                @(negedge clock);
                auto_done = 1'b0;
                auto_busy = 1'b0;
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] cmd;
        logic [7:0] val;
        logic       busy;
        logic       done;
        logic       e_start;
        logic [7:0] e_cmd;
        logic [7:0] e_val;
        logic [2:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        in_valid   = v.valid;
        in_command = v.cmd;
        in_value   = v.val;
        man_busy   = v.busy;
        man_done   = v.done;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] v);
        in_valid   = 1'b1;
        in_command = c;
        in_value   = v;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic doReset;
        auto_en    = 1'b0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_command = 8'h00;
        in_value   = 8'h00;
        man_busy   = 1'b0;
        man_done   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic waitFrames(input int n, input int budget, input string name);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        checkOutput(name, got.size(), n);
    endtask

    initial begin
        int p0;
        // Each row: inputs for one cycle, then the outputs expected just after the edge.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA1, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hA2, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'hA3, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hA4, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'hB0, 8'h0B, 1'b0, 1'b0, 1'b1, 8'hA1, 8'h02, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA1, 8'h02, 3'd3, 1'b0, 1'b0, 1'b1};

        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d.out_start", i), out_start, vecs[i].e_start);
            checkOutput($sformatf("v%0d.out_command", i), out_command, vecs[i].e_cmd);
            checkOutput($sformatf("v%0d.out_value", i), out_value, vecs[i].e_val);
            checkOutput($sformatf("v%0d.count", i), count, vecs[i].e_count);
            checkOutput($sformatf("v%0d.empty", i), empty, vecs[i].e_empty);
            checkOutput($sformatf("v%0d.full", i), full, vecs[i].e_full);
            checkOutput($sformatf("v%0d.overflow", i), overflow, vecs[i].e_ovf);
        end

        // Single pair: start one cycle after the push edge, one cycle wide.
        doReset();
        p0 = start_pulses;
        in_valid = 1'b1; in_command = 8'h01; in_value = 8'h2A;
        tick();
        in_valid = 1'b0;
        checkOutput("single.count_after_push", count, 1);
        checkOutput("single.no_start_yet", out_start, 0);
        tick();
        checkOutput("single.start", out_start, 1);
        checkOutput("single.cmd", out_command, 8'h01);
        checkOutput("single.val", out_value, 8'h2A);
        checkOutput("single.empty_at_start", empty, 1);
        man_busy = 1'b1;
        tick();
        checkOutput("single.start_width", out_start, 0);
        repeat (48) tick();
        man_done = 1'b1; man_busy = 1'b0;
        tick();
        man_done = 1'b0;
        repeat (10) tick();
        checkOutput("single.pulse_count", start_pulses - p0, 1);
        checkOutput("single.empty_end", empty, 1);
        checkOutput("single.no_timeout", tx_timeout, 0);

        // Ordering across a pointer wrap, queue never full.
        doReset();
        got.delete();
        max_count = 0;
        auto_lat = 10;
        auto_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(8'h10 + 8'(k), 8'h90 + 8'(k));
            repeat (7) tick();
        end
        waitFrames(6, 600, "order.frames");
        repeat (40) tick();
        checkOutput("order.total_frames", got.size(), 6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            checkOutput($sformatf("order.frame%0d", k), got[k], {8'h10 + 8'(k), 8'h90 + 8'(k)});
        checkOutput("order.max_count_le4", max_count <= 4, 1);
        checkOutput("order.no_overflow", overflow, 0);

        // Overflow: fifth pair dropped, first four emitted in order.
        doReset();
        man_busy = 1'b1;
        for (int k = 0; k < 5; k++) push(8'hC0 + 8'(k), 8'h40 + 8'(k));
        checkOutput("ovf.count", count, 4);
        checkOutput("ovf.full", full, 1);
        checkOutput("ovf.flag", overflow, 1);
        got.delete();
        auto_en = 1'b1;
        waitFrames(4, 400, "ovf.frames");
        repeat (60) tick();
        checkOutput("ovf.total_frames", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            checkOutput($sformatf("ovf.frame%0d", k), got[k], {8'hC0 + 8'(k), 8'h40 + 8'(k)});
        checkOutput("ovf.sticky", overflow, 1);

        // Simultaneous push and pop with one pair queued.
        doReset();
        man_busy = 1'b1;
        push(8'hD0, 8'h11);
        checkOutput("pp.count_before", count, 1);
        got.delete();
        man_busy = 1'b0;
        in_valid = 1'b1; in_command = 8'hD1; in_value = 8'h22;
        tick();
        in_valid = 1'b0;
        checkOutput("pp.count", count, 1);
        checkOutput("pp.start", out_start, 1);
        checkOutput("pp.cmd", out_command, 8'hD0);
        auto_en = 1'b1;
        waitFrames(2, 200, "pp.frames");
        if (got.size() >= 2) checkOutput("pp.second_frame", got[1], 16'hD122);
        repeat (30) tick();
        checkOutput("pp.count_end", count, 0);

        // Transmit timeout: no done strobe ever arrives.
        doReset();
        in_valid = 1'b1; in_command = 8'hE0; in_value = 8'h01;
        tick();
        in_command = 8'hE1; in_value = 8'h02;
        tick();
        in_valid = 1'b0;
        checkOutput("tmo.start", out_start, 1);
        checkOutput("tmo.cmd", out_command, 8'hE0);
        checkOutput("tmo.count", count, 1);
        tick();
        repeat (TMO - 1) tick();
        checkOutput("tmo.not_yet", tx_timeout, 0);
        tick();
        checkOutput("tmo.flag", tx_timeout, 1);
        repeat (GAP) tick();
        checkOutput("tmo.gap_no_start", out_start, 0);
        tick();
        checkOutput("tmo.next_start", out_start, 1);
        checkOutput("tmo.next_cmd", out_command, 8'hE1);
        checkOutput("tmo.next_val", out_value, 8'h02);
        checkOutput("tmo.empty", empty, 1);

        // Reset while waiting for completion with three pairs still queued.
        doReset();
        man_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(8'hF0 + 8'(k), 8'h70 + 8'(k));
        man_busy = 1'b0;
        tick();
        checkOutput("rst.popped_count", count, 3);
        man_busy = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst.count", count, 0);
        checkOutput("rst.start", out_start, 0);
        checkOutput("rst.cmd", out_command, 8'h00);
        checkOutput("rst.val", out_value, 8'h00);
        checkOutput("rst.empty", empty, 1);
        checkOutput("rst.timeout", tx_timeout, 0);
        man_busy = 1'b0;
        p0 = start_pulses;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (20) tick();
        checkOutput("rst.late_done_ignored", start_pulses - p0, 0);
        checkOutput("rst.count_end", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
